// File: rtl/divider_pkg.sv
// Shared constants and state encoding for the iterative divider.
// Optional feature macro used by the divider: DIV_ZERO_FLAG_EN.
package divider_pkg;

  // Operand/result width; must match the shared execute-stage adder.
  localparam int DIV_WIDTH = 32;

  // One quotient bit per iteration.
  localparam int DIV_ITERS = DIV_WIDTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ABS_A = 3'd1,
    ABS_B = 3'd2,
    ITER  = 3'd3,
    FIX_Q = 3'd4,
    FIX_R = 3'd5,
    DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/divider_ctrl.sv
// Sequencer for the divider: walks IDLE -> ABS_A -> ABS_B -> ITER x ITERS
// -> FIX_Q -> FIX_R -> DONE, counts iterations and produces a registered Busy.
module divider_ctrl
  import divider_pkg::*;
#(
  parameter int ITERS = DIV_ITERS
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   div_en,
  output state_t state,
  output logic   busy
);

  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

  logic [CNT_W-1:0] count;

  // State register, iteration counter and Busy flag; DONE waits for the
  // requester to drop DIV_EN so a held request cannot start a second run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (div_en) begin
            state <= ABS_A;
            busy  <= 1'b1;
            count <= '0;
          end
        end
        ABS_A: state <= ABS_B;
        ABS_B: begin
          state <= ITER;
          count <= '0;
        end
        ITER: begin
          if (count == LAST_ITER) begin
            state <= FIX_Q;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        FIX_Q: state <= FIX_R;
        FIX_R: begin
          state <= DONE;
          busy  <= 1'b0;
        end
        DONE: begin
          if (!div_en) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/divider.sv
// Iterative restoring divider (quotient + remainder, signed or unsigned).
// Owns no adder: every subtract and negate goes through the shared external
// adder via DAddInA/DAddInB/DCin, with Sum/DCout coming back.
// Optional feature macro: DIV_ZERO_FLAG_EN adds a registered DivZero output.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             CLK_DIV,
  input  logic             Reset,
  input  logic             DIV_EN,
  input  logic             DIVOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  input  logic [WIDTH-1:0] Sum,
  input  logic             DCout,
  output logic [WIDTH-1:0] DAddInA,
  output logic [WIDTH-1:0] DAddInB,
  output logic             DCin,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic             DivZero
`endif
);

  localparam int ITERS = WIDTH;

  state_t state;

  // a keeps the original dividend (needed for the divide-by-zero remainder
  // and its sign), d becomes |divisor|, q starts as |dividend| and shifts
  // into the quotient, r is the partial remainder.
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             is_signed;
  logic             sign2;
  logic             div_zero;

  logic [WIDTH-1:0] rs;
  logic             accept;
  logic             neg_q;
  logic             neg_r;

  assign rs     = {r[WIDTH-2:0], q[WIDTH-1]};
  assign accept = DCout | r[WIDTH-1];
  assign neg_q  = is_signed & (a[WIDTH-1] ^ sign2);
  assign neg_r  = is_signed & a[WIDTH-1];

  divider_ctrl #(
    .ITERS(ITERS)
  ) u_ctrl (
    .clk   (CLK_DIV),
    .rst   (Reset),
    .div_en(DIV_EN),
    .state (state),
    .busy  (Busy)
  );

  // Shared-adder requests: negate is 0 + ~x + 1, trial subtract is rs + ~d + 1;
  // all zero outside the active states so the adder mux can OR requesters.
  always_comb begin
    DAddInA = '0;
    DAddInB = '0;
    DCin    = 1'b0;
    case (state)
      ABS_A: begin
        DAddInB = ~a;
        DCin    = 1'b1;
      end
      ABS_B: begin
        DAddInB = ~d;
        DCin    = 1'b1;
      end
      ITER: begin
        DAddInA = rs;
        DAddInB = ~d;
        DCin    = 1'b1;
      end
      FIX_Q: begin
        DAddInB = ~q;
        DCin    = 1'b1;
      end
      FIX_R: begin
        DAddInB = ~r;
        DCin    = 1'b1;
      end
      default: begin
        DAddInA = '0;
        DAddInB = '0;
        DCin    = 1'b0;
      end
    endcase
  end

  // Datapath registers: latch operands on start, take magnitudes, run the
  // restoring iterations, apply sign fixups and publish results on the way
  // into DONE (the same edge Busy falls).
  always_ff @(posedge CLK_DIV or posedge Reset) begin
    if (Reset) begin
      a         <= '0;
      d         <= '0;
      q         <= '0;
      r         <= '0;
      is_signed <= 1'b0;
      sign2     <= 1'b0;
      div_zero  <= 1'b0;
      Result    <= '0;
      Remainder <= '0;
`ifdef DIV_ZERO_FLAG_EN
      DivZero   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (DIV_EN) begin
            a         <= Operand1;
            d         <= Operand2;
            is_signed <= DIVOp;
            sign2     <= Operand2[WIDTH-1];
            div_zero  <= (Operand2 == '0);
          end
        end
        ABS_A: begin
          q <= (is_signed & a[WIDTH-1]) ? Sum : a;
          r <= '0;
        end
        ABS_B: begin
          if (is_signed & d[WIDTH-1]) d <= Sum;
        end
        ITER: begin
          r <= accept ? Sum : rs;
          q <= {q[WIDTH-2:0], accept};
        end
        FIX_Q: begin
          if (neg_q & ~div_zero) q <= Sum;
        end
        FIX_R: begin
          if (div_zero) begin
            Result    <= '1;
            Remainder <= a;
          end else begin
            Result    <= q;
            Remainder <= neg_r ? Sum : r;
          end
`ifdef DIV_ZERO_FLAG_EN
          DivZero <= div_zero;
`endif
        end
        default: begin
          a <= a;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the divider with a behavioural shared adder and a
// scoreboard of expected quotient/remainder pairs.
// Optional feature macro: DIV_ZERO_FLAG_EN (DivZero is also checked).
module tb_divider;

  logic        CLK_DIV = 1'b0;
  logic        Reset;
  logic        DIV_EN;
  logic        DIVOp;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic [31:0] Sum;
  logic        DCout;
  logic [31:0] DAddInA;
  logic [31:0] DAddInB;
  logic        DCin;
  logic [31:0] Result;
  logic [31:0] Remainder;
  logic        Busy;
`ifdef DIV_ZERO_FLAG_EN
  logic        DivZero;
`endif

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 CLK_DIV = ~CLK_DIV;

  // Behavioural model of the shared execute-stage adder.
  assign {DCout, Sum} = {1'b0, DAddInA} + {1'b0, DAddInB} + {32'd0, DCin};

  divider dut (
    .CLK_DIV  (CLK_DIV),
    .Reset    (Reset),
    .DIV_EN   (DIV_EN),
    .DIVOp    (DIVOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Sum      (Sum),
    .DCout    (DCout),
    .DAddInA  (DAddInA),
    .DAddInB  (DAddInB),
    .DCin     (DCin),
    .Result   (Result),
    .Remainder(Remainder),
    .Busy     (Busy)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .DivZero  (DivZero)
`endif
  );

  // Watchdog so a stuck design still ends the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t model(input logic [31:0] o1, input logic [31:0] o2,
                                 input logic s);
    exp_t e;
    logic [31:0] ua, ub, uq, ur;
    e.dz = (o2 == 32'd0);
    if (o2 == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = o1;
    end else begin
      ua = (s && o1[31]) ? (32'd0 - o1) : o1;
      ub = (s && o2[31]) ? (32'd0 - o2) : o2;
      uq = ua / ub;
      ur = ua % ub;
      e.q = (s && (o1[31] ^ o2[31])) ? (32'd0 - uq) : uq;
      e.r = (s && o1[31]) ? (32'd0 - ur) : ur;
    end
    return e;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] got,
                            input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("[TB] FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] o1, input logic [31:0] o2,
                               input logic s);
    @(negedge CLK_DIV);
    Operand1 = o1;
    Operand2 = o2;
    DIVOp    = s;
    DIV_EN   = 1'b1;
    sb.push_back(model(o1, o2, s));
  endtask

  task automatic checkOutput(input string tag);
    int   cyc;
    exp_t e;
    cyc = 0;
    @(negedge CLK_DIV);
    Operand1 = $urandom;
    Operand2 = $urandom;
    DIVOp    = ~DIVOp;
    while (Busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge CLK_DIV);
    end
    checkValue({tag, " busy_cycles"}, 32'(cyc), 32'd36);
    if (sb.size() == 0) begin
      checkValue({tag, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      checkValue({tag, " result"}, Result, e.q);
      checkValue({tag, " remainder"}, Remainder, e.r);
`ifdef DIV_ZERO_FLAG_EN
      checkValue({tag, " divzero"}, 32'(DivZero), 32'(e.dz));
`endif
    end
    checkValue({tag, " adder_idle"}, DAddInA | DAddInB | 32'(DCin), 32'd0);
    DIV_EN = 1'b0;
    @(negedge CLK_DIV);
  endtask

  initial begin
    int pulses;
    logic prev_busy;

    Reset    = 1'b1;
    DIV_EN   = 1'b0;
    DIVOp    = 1'b0;
    Operand1 = '0;
    Operand2 = '0;
    #12;
    checkValue("reset busy", 32'(Busy), 32'd0);
    checkValue("reset result", Result, 32'd0);
    checkValue("reset remainder", Remainder, 32'd0);
    checkValue("reset adder", DAddInA | DAddInB | 32'(DCin), 32'd0);
    @(negedge CLK_DIV);
    Reset = 1'b0;

    $display("[TB] directed divisions");
    applyStimulus(32'd7, 32'd2, 1'b0);                     checkOutput("u7/2");
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1);             checkOutput("s-7/2");
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b0);             checkOutput("uFFFFFFF9/2");
    applyStimulus(32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0);     checkOutput("uFE/FE");
    applyStimulus(32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b1);     checkOutput("s-2/-2");
    applyStimulus(32'hFFFF_FFFE, 32'd2, 1'b1);             checkOutput("s-2/2");
    applyStimulus(32'd5, 32'd0, 1'b0);                     checkOutput("u5/0");
    applyStimulus(32'hFFFF_FFF9, 32'd0, 1'b1);             checkOutput("s-7/0");
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);     checkOutput("s_overflow");
    applyStimulus(32'd100, 32'hFFFF_FFF9, 1'b1);           checkOutput("s100/-7");
    for (int i = 0; i < 4; i++) begin
      applyStimulus($urandom, $urandom_range(1, 32'h0001_FFFF), 1'($urandom_range(0, 1)));
      checkOutput("random");
    end

    $display("[TB] held request");
    applyStimulus(32'd1000, 32'd7, 1'b0);
    pulses    = 0;
    prev_busy = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge CLK_DIV);
      if (Busy === 1'b1 && prev_busy === 1'b0) pulses++;
      prev_busy = Busy;
    end
    checkValue("held busy_pulses", 32'(pulses), 32'd1);
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checkValue("held result", Result, e.q);
      checkValue("held remainder", Remainder, e.r);
    end
    DIV_EN = 1'b0;
    @(negedge CLK_DIV);
    applyStimulus(32'd1001, 32'd10, 1'b0);                 checkOutput("second_start");

    $display("[TB] reset during iteration");
    applyStimulus(32'd7, 32'd2, 1'b0);                     checkOutput("pre_reset");
    @(negedge CLK_DIV);
    Operand1 = 32'd77;
    Operand2 = 32'd5;
    DIVOp    = 1'b0;
    DIV_EN   = 1'b1;
    repeat (12) @(negedge CLK_DIV);
    checkValue("mid_iter busy", 32'(Busy), 32'd1);
    #1 Reset = 1'b1;
    #1;
    checkValue("async busy", 32'(Busy), 32'd0);
    checkValue("async result", Result, 32'd0);
    checkValue("async remainder", Remainder, 32'd0);
    checkValue("async adder", DAddInA | DAddInB | 32'(DCin), 32'd0);
    @(negedge CLK_DIV);
    Reset  = 1'b0;
    DIV_EN = 1'b0;
    @(negedge CLK_DIV);
    applyStimulus(32'd77, 32'd5, 1'b0);                    checkOutput("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
